// File: rtl/kmeans_pkg.sv
`default_nettype none
// ============================================================================
// kmeans_pkg : constants and state encoding shared by the K-means stages
// Revision   : 1.0
// ============================================================================
package kmeans_pkg;

  localparam int NUM_CLUSTERS = 3;
  localparam int NUM_DIM      = 4;
  localparam int NUM_RESULTS  = NUM_CLUSTERS * NUM_DIM;

  localparam logic [1:0] CL0     = 2'b00;
  localparam logic [1:0] CL1     = 2'b01;
  localparam logic [1:0] CL2     = 2'b10;
  localparam logic [1:0] CL_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DIV   = 2'd1,
    ST_OUT   = 2'd2
  } cu_state_t;

endpackage
`default_nettype wire

// File: rtl/kmeans_centroid_update_if.sv
`default_nettype none
// ============================================================================
// kmeans_centroid_update_if : point stream in, centroid result stream out
// Revision                  : 1.0
// ============================================================================
interface kmeans_centroid_update_if #(
  parameter int DATA_W = 16
) ();

  logic              pt_valid;
  logic              pt_ready;
  logic              pt_last;
  logic [DATA_W-1:0] data_in1;
  logic [DATA_W-1:0] data_in2;
  logic [DATA_W-1:0] data_in3;
  logic [DATA_W-1:0] data_in4;
  logic [1:0]        cluster_addr;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_cluster;
  logic [1:0]        res_dim;
  logic [DATA_W-1:0] res_value;
  logic              res_empty;

  modport slave (
    input  pt_valid, pt_last, data_in1, data_in2, data_in3, data_in4,
           cluster_addr, res_ready,
    output pt_ready, res_valid, res_cluster, res_dim, res_value, res_empty
  );

  modport master (
    output pt_valid, pt_last, data_in1, data_in2, data_in3, data_in4,
           cluster_addr, res_ready,
    input  pt_ready, res_valid, res_cluster, res_dim, res_value, res_empty
  );

endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// seq_divider : unsigned restoring divider, one quotient bit per cycle
// Revision    : 1.0
// ============================================================================
module seq_divider #(
  parameter int DVD_W = 32,
  parameter int DVS_W = 16,
  parameter int Q_W   = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             start,
  input  wire logic [DVD_W-1:0] dividend,
  input  wire logic [DVS_W-1:0] divisor,
  output logic                  done,
  output logic [Q_W-1:0]        quotient
);

  localparam int CW = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] r_rem;
  logic [DVS_W-1:0] r_dvs;
  logic [DVD_W-1:0] r_quo;
  logic [CW-1:0]    r_step;
  logic             r_run;

  logic [DVS_W-1:0] w_rem_src;
  logic [DVS_W-1:0] w_dvs;
  logic [DVD_W-1:0] w_quo_src;
  logic [DVS_W:0]   w_trial;
  logic [DVS_W:0]   w_rem_next;
  logic             w_ge;
  logic [DVD_W-1:0] w_quo_next;
  logic             w_unused;

  // The first iteration runs on the start edge so the last one coincides with done.
  always_comb begin
    w_rem_src  = start ? '0 : r_rem;
    w_quo_src  = start ? dividend : r_quo;
    w_dvs      = start ? divisor : r_dvs;
    w_trial    = {w_rem_src, w_quo_src[DVD_W-1]};
    w_ge       = (w_trial >= {1'b0, w_dvs});
    w_rem_next = w_ge ? (w_trial - {1'b0, w_dvs}) : w_trial;
    w_quo_next = {w_quo_src[DVD_W-2:0], w_ge};
  end

  assign done     = r_run && (r_step == CW'(DVD_W - 1));
  assign quotient = w_quo_next[Q_W-1:0];
  assign w_unused = w_rem_next[DVS_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem  <= '0;
      r_dvs  <= '0;
      r_quo  <= '0;
      r_step <= '0;
      r_run  <= 1'b0;
    end else if (start) begin
      r_rem  <= w_rem_next[DVS_W-1:0];
      r_dvs  <= divisor;
      r_quo  <= w_quo_next;
      r_step <= CW'(1);
      r_run  <= 1'b1;
    end else if (r_run) begin
      r_rem  <= w_rem_next[DVS_W-1:0];
      r_quo  <= w_quo_next;
      r_step <= r_step + CW'(1);
      if (done) r_run <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/kmeans_centroid_update.sv
`default_nettype none
// ============================================================================
// kmeans_centroid_update : per-cluster sums/counts, then mean of each coordinate
// Revision               : 1.0
// ============================================================================
module kmeans_centroid_update
  import kmeans_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16,
  parameter int ACC_W  = 32
) (
  input  wire logic               clk,
  input  wire logic               reset,
  kmeans_centroid_update_if.slave bus,
  output logic                    busy,
  output logic                    ovf
);

  cu_state_t        r_state;
  logic [ACC_W-1:0] r_sum [NUM_CLUSTERS][NUM_DIM];
  logic [CNT_W-1:0] r_cnt [NUM_CLUSTERS];
  logic [3:0]       r_idx;
  logic             r_div_run;

  logic [DATA_W-1:0] w_data [NUM_DIM];
  logic [1:0]        w_cl;
  logic [1:0]        w_dim;
  logic              w_cnt_zero;
  logic              w_div_start;
  logic              w_div_done;
  logic [DATA_W-1:0] w_quo;
  logic              w_accept;

  assign w_data[0]   = bus.data_in1;
  assign w_data[1]   = bus.data_in2;
  assign w_data[2]   = bus.data_in3;
  assign w_data[3]   = bus.data_in4;
  assign w_cl        = r_idx[3:2];
  assign w_dim       = r_idx[1:0];
  assign w_cnt_zero  = (r_cnt[w_cl] == '0);
  assign w_div_start = (r_state == ST_DIV) && !r_div_run && !w_cnt_zero;
  assign w_accept    = bus.pt_valid && (r_state == ST_ACCUM);
  assign bus.pt_ready = (r_state == ST_ACCUM);
  assign busy        = (r_state != ST_ACCUM);

  seq_divider #(
    .DVD_W (ACC_W),
    .DVS_W (CNT_W),
    .Q_W   (DATA_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (w_div_start),
    .dividend (r_sum[w_cl][w_dim]),
    .divisor  (r_cnt[w_cl]),
    .done     (w_div_done),
    .quotient (w_quo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_ACCUM;
      r_idx         <= '0;
      r_div_run     <= 1'b0;
      ovf           <= 1'b0;
      bus.res_valid   <= 1'b0;
      bus.res_value   <= '0;
      bus.res_cluster <= '0;
      bus.res_dim     <= '0;
      bus.res_empty   <= 1'b0;
      for (int c = 0; c < NUM_CLUSTERS; c++) begin
        r_cnt[c] <= '0;
        for (int d = 0; d < NUM_DIM; d++) r_sum[c][d] <= '0;
      end
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            if (bus.cluster_addr != CL_NONE) begin
              // A saturated count would corrupt the mean, so the point is dropped.
              if (r_cnt[bus.cluster_addr] == '1) begin
                ovf <= 1'b1;
              end else begin
                r_cnt[bus.cluster_addr] <= r_cnt[bus.cluster_addr] + CNT_W'(1);
                for (int d = 0; d < NUM_DIM; d++)
                  r_sum[bus.cluster_addr][d] <= r_sum[bus.cluster_addr][d] + ACC_W'(w_data[d]);
              end
            end
            if (bus.pt_last) begin
              r_state <= ST_DIV;
              r_idx   <= '0;
            end
          end
        end
        ST_DIV: begin
          if (w_cnt_zero) begin
            bus.res_valid   <= 1'b1;
            bus.res_value   <= '0;
            bus.res_empty   <= 1'b1;
            bus.res_cluster <= w_cl;
            bus.res_dim     <= w_dim;
            r_state         <= ST_OUT;
          end else if (w_div_done) begin
            bus.res_valid   <= 1'b1;
            bus.res_value   <= w_quo;
            bus.res_empty   <= 1'b0;
            bus.res_cluster <= w_cl;
            bus.res_dim     <= w_dim;
            r_div_run       <= 1'b0;
            r_state         <= ST_OUT;
          end else if (w_div_start) begin
            r_div_run <= 1'b1;
          end
        end
        ST_OUT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            if (r_idx == 4'(NUM_RESULTS - 1)) begin
              for (int c = 0; c < NUM_CLUSTERS; c++) begin
                r_cnt[c] <= '0;
                for (int d = 0; d < NUM_DIM; d++) r_sum[c][d] <= '0;
              end
              r_state <= ST_ACCUM;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= ST_DIV;
            end
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kmeans_centroid_update.sv
`default_nettype none
// ============================================================================
// tb_kmeans_centroid_update : random and directed epochs against a mean model
// Revision                  : 1.0
// ============================================================================
module tb_kmeans_centroid_update;
  import kmeans_pkg::*;

  localparam int DATA_W  = 16;
  localparam int CNT_W   = 16;
  localparam int ACC_W   = 32;
  localparam int DIV_LAT = ACC_W + 1;

  logic clk = 1'b0;
  logic reset;
  logic busy, ovf, s_busy, s_ovf;

  kmeans_centroid_update_if #(.DATA_W(DATA_W)) bus ();
  kmeans_centroid_update_if #(.DATA_W(DATA_W)) sbus ();

  kmeans_centroid_update #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .ovf(ovf));

  // Tiny count width so saturation is reachable in a handful of points.
  kmeans_centroid_update #(.DATA_W(DATA_W), .CNT_W(2), .ACC_W(ACC_W)) dut_sat (
    .clk(clk), .reset(reset), .bus(sbus), .busy(s_busy), .ovf(s_ovf));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: plain per-cluster sums and counts of the current epoch.
  longint m_sum [3][4];
  int     m_cnt [3];

  function automatic void mdl_clear();
    for (int c = 0; c < 3; c++) begin
      m_cnt[c] = 0;
      for (int d = 0; d < 4; d++) m_sum[c][d] = 0;
    end
  endfunction

  function automatic void mdl_add(input int a, input int d0, input int d1, input int d2, input int d3);
    if (a != 3) begin
      m_cnt[a]++;
      m_sum[a][0] += d0;
      m_sum[a][1] += d1;
      m_sum[a][2] += d2;
      m_sum[a][3] += d3;
    end
  endfunction

  task automatic send_point(input int d0, input int d1, input int d2, input int d3,
                            input int a, input bit last);
    @(negedge clk);
    check_eq("pt_ready_accum", bus.pt_ready, 1);
    bus.pt_valid     = 1'b1;
    bus.pt_last      = last;
    bus.data_in1     = 16'(d0);
    bus.data_in2     = 16'(d1);
    bus.data_in3     = 16'(d2);
    bus.data_in4     = 16'(d3);
    bus.cluster_addr = 2'(a);
    @(posedge clk);
    mdl_add(a, d0, d1, d2, d3);
  endtask

  task automatic send_random_epoch(input int max_pts);
    int n;
    n = $urandom_range(max_pts, 1);
    for (int p = 0; p < n; p++)
      send_point($urandom_range(65535, 0), $urandom_range(65535, 0), $urandom_range(65535, 0),
                 $urandom_range(65535, 0), $urandom_range(3, 0), p == n - 1);
  endtask

  task automatic get_results(input int stall_lo, input int stall_hi);
    int     cl, dm, k, stalls;
    bit     emp;
    longint val;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cl  = i / 4;
      dm  = i % 4;
      emp = (m_cnt[cl] == 0);
      val = emp ? 0 : m_sum[cl][dm] / m_cnt[cl];
      k   = 0;
      do begin
        @(negedge clk);
        bus.pt_valid = 1'b0;
        k++;
      end while (!bus.res_valid && k < 200);
      check_eq("res_latency", k, emp ? 2 : DIV_LAT);
      if (!bus.res_valid) return;
      check_eq("res_cluster", bus.res_cluster, cl);
      check_eq("res_dim", bus.res_dim, dm);
      check_eq("res_value", bus.res_value, val);
      check_eq("res_empty", bus.res_empty, emp);
      check_eq("busy_out", busy, 1);
      check_eq("pt_ready_busy", bus.pt_ready, 0);
      stalls = $urandom_range(stall_hi, stall_lo);
      for (int s = 0; s < stalls; s++) begin
        bus.pt_valid     = 1'b1;
        bus.pt_last      = 1'b1;
        bus.cluster_addr = CL0;
        bus.data_in1     = 16'($urandom_range(65535, 0));
        @(negedge clk);
        check_eq("stall_valid", bus.res_valid, 1);
        check_eq("stall_value", bus.res_value, val);
        check_eq("stall_cluster", bus.res_cluster, cl);
        check_eq("stall_dim", bus.res_dim, dm);
        check_eq("stall_pt_ready", bus.pt_ready, 0);
      end
      bus.pt_valid  = 1'b0;
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1 bus.res_ready = 1'b0;
    end
    @(negedge clk);
    check_eq("accum_pt_ready", bus.pt_ready, 1);
    check_eq("accum_busy", busy, 0);
    check_eq("accum_res_valid", bus.res_valid, 0);
  endtask

  task automatic check_reset_vals();
    check_eq("rst_pt_ready", bus.pt_ready, 1);
    check_eq("rst_res_valid", bus.res_valid, 0);
    check_eq("rst_res_value", bus.res_value, 0);
    check_eq("rst_res_cluster", bus.res_cluster, 0);
    check_eq("rst_res_dim", bus.res_dim, 0);
    check_eq("rst_res_empty", bus.res_empty, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ovf", ovf, 0);
  endtask

  task automatic run_saturation();
    int k;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check_eq("sat_ovf_before", s_ovf, 0);
      sbus.pt_valid     = 1'b1;
      sbus.cluster_addr = CL0;
      sbus.data_in1     = (j == 3) ? 16'd100 : 16'd3;
    end
    @(negedge clk);
    check_eq("sat_ovf_set", s_ovf, 1);
    sbus.cluster_addr = CL_NONE;
    sbus.pt_last      = 1'b1;
    @(posedge clk);
    #1 sbus.pt_valid = 1'b0;
    sbus.res_ready = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!sbus.res_valid && k < 200);
    check_eq("sat_first_valid", sbus.res_valid, 1);
    check_eq("sat_value", sbus.res_value, 3);
    check_eq("sat_empty", sbus.res_empty, 0);
    k = 0;
    do begin @(negedge clk); k++; end while (s_busy && k < 1000);
    check_eq("sat_drained", s_busy, 0);
    check_eq("sat_ovf_sticky", s_ovf, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.pt_valid = 1'b0; bus.pt_last = 1'b0; bus.res_ready = 1'b0; bus.cluster_addr = '0;
    bus.data_in1 = '0; bus.data_in2 = '0; bus.data_in3 = '0; bus.data_in4 = '0;
    sbus.pt_valid = 1'b0; sbus.pt_last = 1'b0; sbus.res_ready = 1'b0; sbus.cluster_addr = '0;
    sbus.data_in1 = '0; sbus.data_in2 = '0; sbus.data_in3 = '0; sbus.data_in4 = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;

    run_saturation();

    mdl_clear();
    send_point(10, 20, 30, 40, 0, 1'b0);
    send_point(20, 40, 60, 80, 0, 1'b1);
    get_results(0, 0);

    mdl_clear();
    send_point(1, 2, 3, 65535, 1, 1'b0);
    send_point(2, 3, 3, 65535, 1, 1'b1);
    get_results(0, 1);

    mdl_clear();
    send_point(7, 7, 7, 7, 3, 1'b1);
    get_results(0, 0);
    check_eq("discard_ovf", ovf, 0);

    mdl_clear();
    send_random_epoch(4);
    get_results(5, 5);

    mdl_clear();
    send_point(9, 9, 9, 9, 0, 1'b0);
    send_point(5, 6, 7, 8, 1, 1'b1);
    repeat (10) @(negedge clk);
    bus.pt_valid = 1'b0;
    check_eq("mid_div_busy", busy, 1);
    reset = 1'b1;
    #1 check_reset_vals();
    @(negedge clk);
    reset = 1'b0;

    mdl_clear();
    send_point(4, 4, 4, 4, 2, 1'b1);
    get_results(0, 0);

    mdl_clear();
    send_point(8, 8, 8, 8, 0, 1'b1);
    get_results(0, 2);

    for (int e = 0; e < 3; e++) begin
      mdl_clear();
      send_random_epoch(20);
      get_results(0, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
